two_bit_demux: RTL

TWO_BIT_DEMUX -- requirements
Module: two_bit_demux

---
 rtl/two_bit_demux.sv | 128 ++++++++++++
 1 files changed

// File: rtl/two_bit_demux.sv
// -----------------------------------------------------------------------------
// two_bit_demux
//
// Routes 2-bit words from one valid/ready input stream to one of two output
// channels. Each channel has its own 2-entry FIFO, so a stalled channel never
// blocks traffic bound for the other one. Every channel also counts the words
// its consumer has taken.
//
// Parameters
//   CNT_W     width of each delivered-word counter (1..16); it wraps silently
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst_n     asynchronous active-low reset; clears FIFOs, pointers, counters
//   in_data   word to route
//   in_sel    destination: 1 -> channel A, 0 -> channel B
//   in_valid  in_data / in_sel are valid
//   in_ready  the selected FIFO has room (combinational on in_sel)
//   a_data    channel A head word (2'b00 when empty)
//   a_valid   channel A FIFO is non-empty
//   a_ready   channel A consumer takes the head word
//   b_data    channel B head word (2'b00 when empty)
//   b_valid   channel B FIFO is non-empty
//   b_ready   channel B consumer takes the head word
//   a_count   words delivered on channel A
//   b_count   words delivered on channel B
// -----------------------------------------------------------------------------
module two_bit_demux #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [1:0]       b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Channel index 0 is A, index 1 is B.
    logic [1:0]       ch_ready;
    logic [1:0]       ch_valid;
    logic [1:0]       ch_full;
    logic [1:0]       ch_data  [2];
    logic [CNT_W-1:0] ch_count [2];
    logic             accept;

    assign ch_ready = {b_ready, a_ready};

    // Readiness looks only at the FIFO the current word targets. A full FIFO
    // stays not-ready even if it is popped this cycle: no pass-through path.
    assign in_ready = rst_n & ~(in_sel ? ch_full[0] : ch_full[1]);
    assign accept   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            // in_sel value that steers a word into this channel
            localparam logic SEL_CODE = (gi == 0) ? 1'b1 : 1'b0;

            logic [1:0]       mem_reg [2];
            logic             wr_ptr_reg;
            logic             rd_ptr_reg;
            logic [1:0]       occ_reg;
            logic [1:0]       occ_next;
            logic [CNT_W-1:0] count_reg;
            logic             push;
            logic             pop;

            assign push = accept & (in_sel == SEL_CODE);
            assign pop  = ch_valid[gi] & ch_ready[gi];

            // Simultaneous push and pop leaves occupancy unchanged.
            always_comb begin
                occ_next = occ_reg;
                if (push && !pop) begin
                    occ_next = occ_reg + 2'd1;
                end else if (!push && pop) begin
                    occ_next = occ_reg - 2'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[0] <= 2'b00;
                    mem_reg[1] <= 2'b00;
                    wr_ptr_reg <= 1'b0;
                    rd_ptr_reg <= 1'b0;
                    occ_reg    <= 2'd0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        mem_reg[wr_ptr_reg] <= in_data;
                        wr_ptr_reg          <= ~wr_ptr_reg;
                    end
                    if (pop) begin
                        rd_ptr_reg <= ~rd_ptr_reg;
                        count_reg  <= count_reg + CNT_ONE;
                    end
                    occ_reg <= occ_next;
                end
            end

            assign ch_valid[gi] = (occ_reg != 2'd0);
            assign ch_full[gi]  = (occ_reg == 2'd2);
            // Empty FIFO presents zero rather than a stale entry.
            assign ch_data[gi]  = ch_valid[gi] ? mem_reg[rd_ptr_reg] : 2'b00;
            assign ch_count[gi] = count_reg;
        end
    endgenerate

    assign a_valid = ch_valid[0];
    assign a_data  = ch_data[0];
    assign a_count = ch_count[0];
    assign b_valid = ch_valid[1];
    assign b_data  = ch_data[1];
    assign b_count = ch_count[1];

endmodule
